audio_i2s_tx: RTL and testbench
===============================

AUDIO_I2S_TX -- requirements
Module: audio_i2s_tx

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; there SHALL be no other clock or reset.
REQ-002 Parameter IN_BITS, default 6: width of the unsigned mapper audio sample; the legal range SHALL be 1..16.
REQ-003 Parameter BCLK_DIV, default 4: clk cycles per bit-clock period; it SHALL be even and at least 2.
REQ-004 Port clk, input, 1 bit: sole clock; all state SHALL update on its rising edge.
REQ-005 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 Port sample_in, input, IN_BITS bits: unsigned expansion-audio level from the mapper; it is asynchronous to frames and held between updates.
REQ-007 Port mute, input, 1 bit: when 1, the next latched word SHALL be 0x0000.
REQ-008 Port i2s_bclk, output, 1 bit: bit clock.
REQ-009 Port i2s_lrck, output, 1 bit: word select; 0 selects the left channel and 1 selects the right channel.
REQ-010 Port i2s_sdata, output, 1 bit: serial data, MSB first.
REQ-011 Port frame_strobe, output, 1 bit: one-clk pulse each time a new word is latched.

Function
REQ-012 div_cnt SHALL count 0..BCLK_DIV-1 and then wrap; tick SHALL be defined as div_cnt == BCLK_DIV-1.
REQ-013 i2s_bclk SHALL be 1 when div_cnt >= BCLK_DIV/2, else 0. It SHALL be decoded from registers only, so that it is glitch-free and has a 50% duty cycle.
REQ-014 bit_cnt SHALL be 6 bits and SHALL increment on tick, wrapping 63 -> 0. One frame is 64 BCLK periods, which is 64*BCLK_DIV clk cycles.
REQ-015 i2s_lrck SHALL equal bit_cnt[5].
REQ-016 Each channel SHALL occupy a 32-bit slot, with s = bit_cnt[4:0] as the position within the slot.
REQ-017 i2s_sdata SHALL equal word[16-s] for s in 1..16, and 0 for s = 0 and for s = 17..31. This gives the standard I2S one-BCLK MSB delay.
REQ-018 Data and lrck SHALL change only on the bclk falling edge (div_cnt 0) and SHALL be stable while bclk is high.
REQ-019 Conversion SHALL be word = ({sample_in, (16-IN_BITS) zero bits}) XOR 0x8000, i.e. offset-binary to two's-complement; when mute = 1, word SHALL be 0x0000.
REQ-020 word SHALL be latched from sample_in and mute on the tick where bit_cnt == 63, so the new frame begins with bit_cnt = 0.
REQ-021 Between latches, word SHALL be held; a sample_in or mute change mid-frame SHALL NOT affect the current frame.
REQ-022 Both channels SHALL transmit the same word (mono duplicated to left and right).
REQ-023 frame_strobe SHALL be registered and SHALL be 1 for exactly the one clk following each latching edge.
REQ-024 Latency: the MSB of a latched sample SHALL appear on i2s_sdata exactly BCLK_DIV clk cycles after the latching edge.

Reset
REQ-025 While reset = 1: div_cnt = 0, bit_cnt = 0, word = 0x0000, frame_strobe = 0, i2s_bclk = 0, i2s_lrck = 0, i2s_sdata = 0.
REQ-026 Reset asserted mid-frame SHALL take effect on the next clk edge and SHALL abort the frame with no partial completion.
REQ-027 After reset deasserts, the first frame SHALL transmit word 0x0000. The first latch SHALL occur at that frame's end, which is 256 clks after deassertion when BCLK_DIV = 4.

Verification (BCLK_DIV=4, IN_BITS=6; frame = 256 clks)
REQ-028 Reset held for 5 clks, then released with sample_in = 0x3F -> all outputs are 0 during reset; frame 0 sdata is all 0; frame_strobe pulses exactly once, 256 clks after release.
REQ-029 sample_in = 0x3F held -> frame 1 carries word 0x7C00 in both slots; the bits at s = 1..16 are 0111110000000000; sdata is 0 at s = 0 and s = 17..31.
REQ-030 sample_in = 0x00 -> word 0x8000: a 1 at s = 1 and 0 on every other bit; the lrck period is 256 clks and the bclk period is 4 clks.
REQ-031 sample_in = 0x20, switched to 0x10 at clk 100 of a frame -> the current frame sends 0x0000 and the next frame sends 0xC000; mute = 1 with 0x3F -> 0x0000.
REQ-032 Reset pulsed at clk 130 of a frame -> the next cycle shows bclk = 0, lrck = 0, sdata = 0; the counters restart; the bench checks REQ-024 latency on the following latch.

Source files
------------

// File: rtl/audio_i2s_tx.sv
// Mono I2S transmitter: expands an unsigned mapper sample to a 16-bit two's-complement word
// and sends it in both 32-bit slots of a 64-BCLK frame with the standard one-bit MSB delay.
module audio_i2s_tx #(
  parameter int IN_BITS  = 6,
  parameter int BCLK_DIV = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [IN_BITS-1:0] sample_in,
  input  logic               mute,
  output logic               i2s_bclk,
  output logic               i2s_lrck,
  output logic               i2s_sdata,
  output logic               frame_strobe
);

  localparam int DW = $clog2(BCLK_DIV);
  localparam int SHIFT = 16 - IN_BITS;
  localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(BCLK_DIV / 2);

  if (IN_BITS < 1 || IN_BITS > 16) begin : g_bad_in_bits
    $error("audio_i2s_tx: IN_BITS must be in 1..16");
  end
  if (BCLK_DIV < 2 || (BCLK_DIV % 2) != 0) begin : g_bad_bclk_div
    $error("audio_i2s_tx: BCLK_DIV must be even and at least 2");
  end

  logic [DW-1:0] div_cnt;
  logic [5:0]    bit_cnt;
  logic [15:0]   word;
  logic          tick;
  logic          frame_end;
  logic [4:0]    slot_pos;
  logic [3:0]    bit_idx;
  logic [15:0]   next_word;

  assign tick      = (div_cnt == DIV_LAST);
  assign frame_end = tick && (bit_cnt == 6'd63);
  assign slot_pos  = bit_cnt[4:0];
  assign bit_idx   = 4'(5'd16 - slot_pos);

  // Left-justify the sample, then flip the MSB to turn offset-binary into two's complement.
  assign next_word = mute ? 16'h0000 : ((16'(sample_in) << SHIFT) ^ 16'h8000);

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt      <= '0;
      bit_cnt      <= '0;
      word         <= 16'h0000;
      frame_strobe <= 1'b0;
    end else begin
      div_cnt      <= tick ? '0 : div_cnt + 1'b1;
      frame_strobe <= frame_end;
      if (tick) begin
        bit_cnt <= bit_cnt + 6'd1;
      end
      if (frame_end) begin
        word <= next_word;
      end
    end
  end

  // All outputs decode registered state only; bit_cnt and word move solely at div_cnt wrap,
  // which is the bclk falling edge, so data and lrck are steady while bclk is high.
  assign i2s_bclk  = (div_cnt >= DIV_HALF);
  assign i2s_lrck  = bit_cnt[5];
  assign i2s_sdata = (slot_pos != 5'd0 && slot_pos <= 5'd16) ? word[bit_idx] : 1'b0;

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Bench for audio_i2s_tx (IN_BITS=6, BCLK_DIV=4): frame-by-frame vector table with
// expected words, plus reset, mid-frame reset and latch-to-MSB latency sequences.
module tb_audio_i2s_tx;

  logic       clk;
  logic       reset;
  logic [5:0] sample_in;
  logic       mute;
  logic       i2s_bclk;
  logic       i2s_lrck;
  logic       i2s_sdata;
  logic       frame_strobe;

  int passed = 0;
  int total  = 0;

  audio_i2s_tx #(.IN_BITS(6), .BCLK_DIV(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .sample_in    (sample_in),
    .mute         (mute),
    .i2s_bclk     (i2s_bclk),
    .i2s_lrck     (i2s_lrck),
    .i2s_sdata    (i2s_sdata),
    .frame_strobe (frame_strobe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  sample;      // driven at frame start
    logic        mute;
    int          chg_at;      // clk index in the frame for an input change, -1 for none
    logic [5:0]  chg_sample;
    logic        chg_mute;
    logic [15:0] next_word;   // word the following frame must carry
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else passed++;
  endtask

  // Samples 256 consecutive negedges starting at the current one (frame position 0)
  // and leaves the bench on position 0 of the next frame.
  task automatic capture_frame(input logic [15:0] exp_word, input logic exp_strobe0,
                               input int chg_at, input logic [5:0] chg_sample,
                               input logic chg_mute, input string tag);
    logic [15:0] left_w, right_w;
    logic [5:0]  bitc;
    logic [4:0]  s;
    bit z_ok, b_ok, lr_ok, st_ok;
    left_w = '0; right_w = '0;
    z_ok = 1; b_ok = 1; lr_ok = 1; st_ok = 1;
    for (int n = 0; n < 256; n++) begin
      if (n == chg_at) begin
        sample_in = chg_sample;
        mute      = chg_mute;
      end
      bitc = 6'(n / 4);
      s    = bitc[4:0];
      if (i2s_bclk !== ((n % 4) >= 2)) b_ok = 0;
      if (i2s_lrck !== bitc[5]) lr_ok = 0;
      if (frame_strobe !== ((n == 0) ? exp_strobe0 : 1'b0)) st_ok = 0;
      if (s >= 5'd1 && s <= 5'd16) begin
        if (bitc[5]) right_w[16 - s] = i2s_sdata;
        else         left_w[16 - s]  = i2s_sdata;
      end else if (i2s_sdata !== 1'b0) begin
        z_ok = 0;
      end
      @(negedge clk);
    end
    check({tag, " left_word"},  32'(left_w),  32'(exp_word));
    check({tag, " right_word"}, 32'(right_w), 32'(exp_word));
    check({tag, " idle_bits_zero"}, 32'(z_ok),  32'd1);
    check({tag, " bclk_pattern"},   32'(b_ok),  32'd1);
    check({tag, " lrck_pattern"},   32'(lr_ok), 32'd1);
    check({tag, " strobe_pattern"}, 32'(st_ok), 32'd1);
  endtask

  initial begin
    int lat;
    logic [15:0] prev_word;

    //           sample  mute chg  chg_s  chg_m  next_word
    vecs[0] = '{6'h3F, 1'b0,  -1, 6'h00, 1'b0, 16'h7C00};
    vecs[1] = '{6'h00, 1'b0,  -1, 6'h00, 1'b0, 16'h8000};
    vecs[2] = '{6'h20, 1'b0,  -1, 6'h00, 1'b0, 16'h0000};
    vecs[3] = '{6'h20, 1'b0, 100, 6'h10, 1'b0, 16'hC000};
    vecs[4] = '{6'h3F, 1'b1,  -1, 6'h00, 1'b0, 16'h0000};
    vecs[5] = '{6'h2A, 1'b0,  -1, 6'h00, 1'b0, 16'h2800};
    vecs[6] = '{6'h00, 1'b0, 100, 6'h00, 1'b1, 16'h0000};

    reset     = 1'b1;
    sample_in = 6'h3F;
    mute      = 1'b0;

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("reset_outputs_%0d", i),
            {28'd0, i2s_bclk, i2s_lrck, i2s_sdata, frame_strobe}, 32'd0);
    end
    reset = 1'b0;

    // Frame 0 after release always carries zero; frame k+1 carries vecs[k].next_word.
    prev_word = 16'h0000;
    for (int k = 0; k < 7; k++) begin
      sample_in = vecs[k].sample;
      mute      = vecs[k].mute;
      capture_frame(prev_word, (k == 0) ? 1'b0 : 1'b1, vecs[k].chg_at,
                    vecs[k].chg_sample, vecs[k].chg_mute, $sformatf("frame%0d", k));
      prev_word = vecs[k].next_word;
    end
    sample_in = 6'h3F;
    mute      = 1'b0;
    capture_frame(prev_word, 1'b1, -1, 6'h00, 1'b0, "frame7");

    // Mid-frame reset at clk 130 of frame 8.
    repeat (130) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midframe_reset_outputs",
          {28'd0, i2s_bclk, i2s_lrck, i2s_sdata, frame_strobe}, 32'd0);
    reset     = 1'b0;
    sample_in = 6'h00;
    capture_frame(16'h0000, 1'b0, -1, 6'h00, 1'b0, "post_reset_frame0");

    check("latch_strobe", 32'(frame_strobe), 32'd1);
    lat = -1;
    for (int k = 0; k < 20; k++) begin
      if (i2s_sdata === 1'b1) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
    check("latch_to_msb_latency", 32'(lat), 32'd4);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
